dcache_wb: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the single-cycle CPU's byte-wide load/store port and the word-wide data memory. It answers hits in the same cycle and stalls the CPU through `BUSYWAIT` on misses. Dirty victims are written back to memory, then the missing block is fetched and installed. It replaces the CPU-to-memory path for all data accesses; the instruction side is separate.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_array.sv | 70 +++++++
 rtl/dcache_wb.sv | 215 +++++++++++++++++++++
 tb/tb_dcache_wb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared geometry constants and FSM state encoding for the
//               direct-mapped write-back data cache (8 lines, 4-byte blocks,
//               8-bit byte address: tag [7:5], index [4:2], offset [1:0]).
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 8;
    localparam int BLOCK_W  = 32;
    localparam int BYTE_W   = 8;
    localparam int MADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Tag/data storage for the data cache. Holds valid, dirty, tag
//               and 32-bit data per line, all cleared by the asynchronous
//               reset. Lookup is combinational; byte writes and block fills
//               take effect on the rising clock edge.
// Ports       : clk, rst            - clock, async active-high clear
//               i_index             - lookup index
//               o_valid/o_dirty/o_tag/o_data - contents of the indexed line
//               i_byte_we/i_offset/i_byte    - store one byte into the
//                                              indexed line, sets dirty
//               i_fill_we/i_fill_index/i_fill_tag/i_fill_data - install a
//                                              whole block, valid=1 dirty=0
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  i_index,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [BLOCK_W-1:0]  o_data,
    input  logic                i_byte_we,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [BYTE_W-1:0]   i_byte,
    input  logic                i_fill_we,
    input  logic [INDEX_W-1:0]  i_fill_index,
    input  logic [TAG_W-1:0]    i_fill_tag,
    input  logic [BLOCK_W-1:0]  i_fill_data
);

    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [BLOCK_W-1:0] r_data [LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Fill and byte write are never requested in the same cycle
            // (fill only in UPDATE, store only in IDLE); fill wins anyway.
            if (i_fill_we) begin
                r_data[i_fill_index]  <= i_fill_data;
                r_tag[i_fill_index]   <= i_fill_tag;
                r_valid[i_fill_index] <= 1'b1;
                r_dirty[i_fill_index] <= 1'b0;
            end else if (i_byte_we) begin
                r_data[i_index][{i_offset, 3'b000} +: BYTE_W] <= i_byte;
                r_dirty[i_index] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wb
// Description : Direct-mapped, write-back, write-allocate data cache between
//               the CPU byte load/store port and word-wide data memory.
//               Hits complete with no stall; misses stall the CPU through
//               BUSYWAIT while a dirty victim is written back (WRITEBACK),
//               the block is fetched (FETCH) and installed (UPDATE).
// Ports       : CLK, RESET (async, active-high)
//               CPU side : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0],
//                          READDATA[7:0], BUSYWAIT
//               Mem side : MEM_READ, MEM_WRITE, MEM_ADDRESS[5:0],
//                          MEM_WRITEDATA[31:0], MEM_READDATA[31:0],
//                          MEM_BUSYWAIT
// Options     : DCACHE_STATS_EN - adds saturating HIT_COUNT / MISS_COUNT
//                                 outputs (16 bit each)
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wb
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    output logic               BUSYWAIT,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [BYTE_W-1:0]  WRITEDATA,
    output logic [BYTE_W-1:0]  READDATA,
    input  logic [7:0]         ADDRESS,
    input  logic               MEM_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    output logic [MADDR_W-1:0] MEM_ADDRESS
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]        HIT_COUNT,
    output logic [15:0]        MISS_COUNT
`endif
);

    // ------------------------------------------------------------------
    // Address split and line lookup
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;

    assign w_tag    = ADDRESS[7:5];
    assign w_index  = ADDRESS[4:2];
    assign w_offset = ADDRESS[1:0];

    logic               w_line_valid;
    logic               w_line_dirty;
    logic [TAG_W-1:0]   w_line_tag;
    logic [BLOCK_W-1:0] w_line_data;

    state_t             r_state;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [MADDR_W-1:0] r_mem_addr;
    logic [BLOCK_W-1:0] r_mem_wdata;
    logic               r_mem_seen;   // MEM_BUSYWAIT observed high this transfer
    logic [MADDR_W-1:0] r_miss_addr;  // block address of the access that missed
    logic [BLOCK_W-1:0] r_fill_data;

    logic w_hit;
    logic w_req;
    logic w_idle;
    logic w_byte_we;
    logic w_fill_we;
    logic w_mem_done;

    assign w_hit      = w_line_valid && (w_line_tag == w_tag);
    assign w_req      = READ | WRITE;
    assign w_idle     = (r_state == IDLE);
    // WRITE takes priority over READ; a combined request is a store.
    assign w_byte_we  = w_idle & WRITE & w_hit;
    assign w_fill_we  = (r_state == UPDATE);
    // A transfer completes only once memory has acknowledged by going busy
    // and then dropping busy again.
    assign w_mem_done = r_mem_seen & ~MEM_BUSYWAIT;

    dcache_array u_array (
        .clk          (CLK),
        .rst          (RESET),
        .i_index      (w_index),
        .o_valid      (w_line_valid),
        .o_dirty      (w_line_dirty),
        .o_tag        (w_line_tag),
        .o_data       (w_line_data),
        .i_byte_we    (w_byte_we),
        .i_offset     (w_offset),
        .i_byte       (WRITEDATA),
        .i_fill_we    (w_fill_we),
        .i_fill_index (r_mem_addr[INDEX_W-1:0]),
        .i_fill_tag   (r_mem_addr[MADDR_W-1:INDEX_W]),
        .i_fill_data  (r_fill_data)
    );

    // ------------------------------------------------------------------
    // CPU-side outputs
    // ------------------------------------------------------------------
    // RESET masks the stall so the CPU sees no request while the cache is
    // held cleared.
    assign BUSYWAIT = ~RESET & w_req & ~(w_idle & w_hit);
    assign READDATA = w_line_data[{w_offset, 3'b000} +: BYTE_W];

    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;

    // ------------------------------------------------------------------
    // Miss-handling state machine with registered memory requests.
    // The fill uses the latched block address so a request withdrawn by
    // the CPU mid-miss still completes the line it started.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_seen  <= 1'b0;
            r_miss_addr <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mem_seen <= 1'b0;
                    if (w_req && !w_hit) begin
                        r_miss_addr <= ADDRESS[7:2];
                        if (w_line_valid && w_line_dirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {w_line_tag, w_index};
                            r_mem_wdata <= w_line_data;
                        end else begin
                            r_state    <= FETCH;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= ADDRESS[7:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (w_mem_done) begin
                        r_state     <= FETCH;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= r_miss_addr;
                        r_mem_seen  <= 1'b0;
                    end else if (MEM_BUSYWAIT) begin
                        r_mem_seen <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_mem_done) begin
                        r_state     <= UPDATE;
                        r_mem_read  <= 1'b0;
                        r_fill_data <= MEM_READDATA;
                        r_mem_seen  <= 1'b0;
                    end else if (MEM_BUSYWAIT) begin
                        r_mem_seen <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // ------------------------------------------------------------------
    // Hit/miss statistics. An access is classified the first time it is
    // seen in IDLE; r_counted suppresses the re-evaluation that follows
    // the line fill, which would otherwise also count as a hit.
    // ------------------------------------------------------------------
    logic        r_counted;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_counted    <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_idle) begin
            r_counted <= w_req & ~w_hit;
            if (w_req && !r_counted) begin
                if (w_hit) begin
                    if (r_hit_count != 16'hFFFF)
                        r_hit_count <= r_hit_count + 16'd1;
                end else begin
                    if (r_miss_count != 16'hFFFF)
                        r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_wb
// Description : Self-checking bench for dcache_wb. A behavioural word memory
//               with programmable busy length answers the cache; a byte-level
//               reference memory supplies expected load data, and expected
//               memory transactions are queued per access and matched against
//               the transactions the memory model observes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic        READ;
    logic        WRITE;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic [7:0]  ADDRESS;
    logic        MEM_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_READDATA;
    logic [31:0] MEM_WRITEDATA;
    logic [5:0]  MEM_ADDRESS;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    dcache_wb dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUSYWAIT      (BUSYWAIT),
        .READ          (READ),
        .WRITE         (WRITE),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .ADDRESS       (ADDRESS),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_ADDRESS   (MEM_ADDRESS)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    mem_txn_t    obs_q[$];
    mem_txn_t    exp_mem_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] mem [64];
    logic        mem_load;
    int          mem_cnt = 0;
    int          mem_lat = 2;
    int          checks  = 0;
    int          errors  = 0;

    // Memory: busy for mem_lat cycles from the first request cycle, then
    // one non-busy cycle in which the transfer completes.
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < mem_lat);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (mem_load) begin
            for (int j = 0; j < 64; j++)
                mem[j] <= {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)} ^ {4{8'hC3}};
            mem_cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            if (mem_cnt >= mem_lat) begin
                if (MEM_WRITE)
                    mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                mem_cnt <= 0;
            end else begin
                if (mem_cnt == 0)
                    obs_q.push_back({MEM_WRITE, MEM_ADDRESS, (MEM_WRITE ? MEM_WRITEDATA : 32'h0)});
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] blk(input int a6);
        return {ref_mem[4*a6+3], ref_mem[4*a6+2], ref_mem[4*a6+1], ref_mem[4*a6]};
    endfunction

    task automatic expect_mem(input logic wr, input logic [5:0] a, input logic [31:0] d);
        exp_mem_q.push_back({wr, a, d});
    endtask

    task automatic check_mem(input string tag);
        mem_txn_t o;
        mem_txn_t e;
        chk({tag, "/mem_txns"}, obs_q.size(), exp_mem_q.size());
        while (obs_q.size() > 0 && exp_mem_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_mem_q.pop_front();
            chk({tag, "/mem_kind"}, {31'd0, o.wr}, {31'd0, e.wr});
            chk({tag, "/mem_addr"}, {26'd0, o.addr}, {26'd0, e.addr});
            if (e.wr)
                chk({tag, "/mem_wdata"}, o.data, e.data);
        end
        obs_q.delete();
        exp_mem_q.delete();
    endtask

    // One CPU access: drive at the falling edge, count stalled cycles,
    // check load data when the stall clears, release after the commit edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input int exp_stall, input string tag);
        int         stall;
        logic [7:0] e;
        @(negedge CLK);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
        if (rd && !wr)
            exp_rd_q.push_back(ref_mem[a]);
        if (wr)
            ref_mem[a] = d;
        stall = 0;
        #1;
        while (BUSYWAIT === 1'b1 && stall < 200) begin
            stall++;
            @(negedge CLK);
            #1;
        end
        chk({tag, "/stall"}, stall, exp_stall);
        if (rd && !wr) begin
            e = exp_rd_q.pop_front();
            chk({tag, "/readdata"}, {24'd0, READDATA}, {24'd0, e});
        end
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        check_mem(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET     = 1'b1;
        READ      = 1'b1;
        WRITE     = 1'b0;
        ADDRESS   = 8'h47;
        WRITEDATA = 8'h00;
        mem_load  = 1'b1;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = 8'(i) ^ 8'hC3;
        @(posedge CLK);
        #1 mem_load = 1'b0;

        // Reset state, with a request present to show the stall is masked
        @(negedge CLK);
        #1;
        chk("rst/busywait",   {31'd0, BUSYWAIT},  32'd0);
        chk("rst/mem_read",   {31'd0, MEM_READ},  32'd0);
        chk("rst/mem_write",  {31'd0, MEM_WRITE}, 32'd0);
        chk("rst/mem_addr",   {26'd0, MEM_ADDRESS}, 32'd0);
        chk("rst/mem_wdata",  MEM_WRITEDATA, 32'd0);
        chk("rst/readdata",   {24'd0, READDATA}, 32'd0);
        READ    = 1'b0;
        ADDRESS = 8'h00;
        @(negedge CLK);
        RESET = 1'b0;

        // Clean read miss then hits on the same line
        mem_lat = 2;
        expect_mem(1'b0, 6'h00, 32'h0);
        access(1'b1, 1'b0, 8'h00, 8'h00, 5, "rd00_miss");
        access(1'b1, 1'b0, 8'h00, 8'h00, 0, "rd00_hit");
        access(1'b0, 1'b1, 8'h01, 8'h5A, 0, "wr01_hit");
        access(1'b1, 1'b0, 8'h01, 8'h00, 0, "rd01_hit");
        access(1'b1, 1'b0, 8'h03, 8'h00, 0, "rd03_hit");

        // Store miss onto a dirty line: writeback, fetch, then store
        mem_lat = 3;
        expect_mem(1'b1, 6'h00, blk(0));
        expect_mem(1'b0, 6'h08, 32'h0);
        access(1'b0, 1'b1, 8'h21, 8'hA5, 10, "wr21_dirty");
        access(1'b1, 1'b0, 8'h21, 8'h00, 0, "rd21_hit");

        // Load miss onto the now-dirty line brings block 0 back from memory
        expect_mem(1'b1, 6'h08, blk(8));
        expect_mem(1'b0, 6'h00, 32'h0);
        access(1'b1, 1'b0, 8'h01, 8'h00, 10, "rd01_dirty");

        // Clean miss on another index with one busy cycle
        mem_lat = 1;
        expect_mem(1'b0, 6'h11, 32'h0);
        access(1'b1, 1'b0, 8'h47, 8'h00, 4, "rd47_miss");

        // Reset during FETCH aborts the request and invalidates every line
        mem_lat = 4;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 8'h21;
        begin
            int w = 0;
            while (MEM_READ !== 1'b1 && w < 10) begin
                @(negedge CLK);
                w++;
            end
        end
        chk("rstfetch/mem_read_before", {31'd0, MEM_READ}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("rstfetch/mem_read",  {31'd0, MEM_READ}, 32'd0);
        chk("rstfetch/busywait",  {31'd0, BUSYWAIT}, 32'd0);
        chk("rstfetch/mem_addr",  {26'd0, MEM_ADDRESS}, 32'd0);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        obs_q.delete();

        expect_mem(1'b0, 6'h08, 32'h0);
        access(1'b1, 1'b0, 8'h21, 8'h00, 7, "rd21_after_rst");
        expect_mem(1'b0, 6'h11, 32'h0);
        access(1'b1, 1'b0, 8'h47, 8'h00, 7, "rd47_after_rst");

        // READ and WRITE together: treated as a (miss, allocate) store
        mem_lat = 2;
        expect_mem(1'b0, 6'h00, 32'h0);
        access(1'b1, 1'b1, 8'h02, 8'h33, 5, "rdwr02");
        access(1'b1, 1'b0, 8'h02, 8'h00, 0, "rd02_hit");
        access(1'b1, 1'b0, 8'h01, 8'h00, 0, "rd01_hit2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
